audio_serial_rx: RTL and testbench

Serial audio receiver that sits directly upstream of the audio delta-sigma DAC. It deserializes a left-justified, I2S-style stream (bit clock, word select, data) arriving on GPIO pins and buffers selected-channel samples in a small FIFO. It presents each sample to the DAC's parallel sample input using the DAC's ready/acknowledge handshake. All logic runs in the `clk_i` domain; the serial pins are synchronized and oversampled, not used as clocks.

---
 rtl/audio_rx_pkg.sv | 13 +
 rtl/audio_rx_fifo.sv | 56 +++++
 rtl/audio_serial_rx.sv | 170 +++++++++++++++++
 tb/tb_audio_serial_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_rx_pkg.sv
// Shared constants and types for the serial audio receiver.
// Holds the sample width default, drop counter width and FSM states.
package audio_rx_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/audio_rx_fifo.sv
// Small synchronous FIFO feeding the DAC sample port.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module audio_rx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign level   = cnt;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap by width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop_ok)      cnt <= cnt + LW'(1);
      else if (pop_ok && !push_ok) cnt <= cnt - LW'(1);
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_serial_rx.sv
// Left-justified serial audio receiver buffering one channel for the DAC.
// Drop counter present only when AUDIO_RX_OVR_CNT_EN is defined.
module audio_serial_rx
  import audio_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   ch_sel_i,
  input  logic                   clr_i,
  input  logic                   sck_i,
  input  logic                   ws_i,
  input  logic                   sd_i,
  output logic [DATA_W-1:0]      sample_o,
  output logic                   sample_rdy_o,
  input  logic                   sample_ack_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overrun_o,
  output logic [CNT_W-1:0]       ovr_cnt_o
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [2:0] s1;
  logic [2:0] s2;
  logic       sck_q;
  logic       ws_q;
  logic       sck_rise;
  logic       ws_edge;
  logic       ws_s;
  logic       sd_s;

  state_t            state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              slot, slot_n;
  logic              push_n;
  logic [DATA_W-1:0] word_n;
  logic              push_q;
  logic [DATA_W-1:0] word_q;

  logic fifo_full;
  logic fifo_empty;
  logic ovr_evt;

  // Two-stage synchronizers plus previous-value registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1    <= '0;
      s2    <= '0;
      sck_q <= 1'b0;
      ws_q  <= 1'b0;
    end else begin
      s1    <= {sck_i, ws_i, sd_i};
      s2    <= s1;
      sck_q <= s2[2];
      ws_q  <= s2[1];
    end
  end

  assign ws_s     = s2[1];
  assign sd_s     = s2[0];
  assign sck_rise = s2[2] & ~sck_q;
  assign ws_edge  = ws_s ^ ws_q;

  // Deserializer state and commit pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      slot   <= 1'b0;
      push_q <= 1'b0;
      word_q <= '0;
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      cnt    <= cnt_n;
      slot   <= slot_n;
      push_q <= push_n;
      word_q <= word_n;
    end
  end

  // Slot tracking: a ws edge commits then restarts before any bit shift.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    slot_n  = slot;
    push_n  = 1'b0;
    word_n  = sh << (CW'(DATA_W) - cnt);
    unique case (state)
      IDLE: begin
        if (en_i && ws_edge) begin
          state_n = SHIFT;
          sh_n    = '0;
          cnt_n   = '0;
          slot_n  = ws_s;
        end
      end
      SHIFT: begin
        if (!en_i) begin
          state_n = IDLE;
        end else if (ws_edge) begin
          push_n = (slot == ch_sel_i) && (cnt != '0);
          sh_n   = '0;
          cnt_n  = '0;
          slot_n = ws_s;
        end
      end
    endcase
    if (state_n == SHIFT && sck_rise && cnt_n < CW'(DATA_W)) begin
      sh_n  = {sh_n[DATA_W-2:0], sd_s};
      cnt_n = cnt_n + CW'(1);
    end
  end

  audio_rx_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_q),
    .din   (word_q),
    .pop   (sample_ack_i),
    .dout  (sample_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o),
    .drop  (ovr_evt)
  );

  assign sample_rdy_o = ~fifo_empty;

  // Sticky overrun flag; a new drop beats a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        overrun_o <= 1'b0;
    else if (ovr_evt) overrun_o <= 1'b1;
    else if (clr_i)   overrun_o <= 1'b0;
  end

`ifdef AUDIO_RX_OVR_CNT_EN
  logic [CNT_W-1:0] ovr_cnt;

  // Saturating drop counter; clear then count when coincident.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovr_cnt <= '0;
    end else if (ovr_evt) begin
      if (clr_i)             ovr_cnt <= CNT_W'(1);
      else if (~&ovr_cnt)    ovr_cnt <= ovr_cnt + CNT_W'(1);
    end else if (clr_i) begin
      ovr_cnt <= '0;
    end
  end

  assign ovr_cnt_o = ovr_cnt;
`else
  assign ovr_cnt_o = '0;
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_audio_serial_rx.sv
// Self-checking bench for audio_serial_rx with a queue scoreboard.
// Serial stream is driven at clk = 8x sck.
module tb_audio_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ch_sel;
  logic        clr;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        ack;
  logic [15:0] sample;
  logic        rdy;
  logic [2:0]  level;
  logic        ovr;
  logic [7:0]  ovr_cnt;

  always #5 clk = ~clk;

  audio_serial_rx #(.DATA_W(16), .DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .ch_sel_i     (ch_sel),
    .clr_i        (clr),
    .sck_i        (sck),
    .ws_i         (ws),
    .sd_i         (sd),
    .sample_o     (sample),
    .sample_rdy_o (rdy),
    .sample_ack_i (ack),
    .level_o      (level),
    .overrun_o    (ovr),
    .ovr_cnt_o    (ovr_cnt)
  );

  typedef struct {
    logic        slot;
    int          nbits;
    logic [31:0] data;
    logic        push;
    logic [15:0] word;
  } vec_t;

  vec_t        tbl [8];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q [$];
  bit          exp_ovr = 0;
  int          exp_cnt = 0;
  bit          pend_v = 0;
  logic [15:0] pend_w = '0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int cnt_out();
`ifdef AUDIO_RX_OVR_CNT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic sb_push(input logic [15:0] w);
    if (exp_q.size() == 4) begin
      exp_ovr = 1;
      if (exp_cnt < 255) exp_cnt++;
    end else begin
      exp_q.push_back(w);
    end
  endtask

  task automatic commit_pend();
    if (pend_v) sb_push(pend_w);
    pend_v = 0;
  endtask

  task automatic send_bits(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sd = d[i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic start_slot(input logic s, input logic [31:0] d,
                            input int n, input logic p,
                            input logic [15:0] w);
    ws = s;
    commit_pend();
    pend_v = p;
    pend_w = w;
    tick(4);
    send_bits(d, n);
  endtask

  task automatic close_slot(input bit with_ack);
    ws = ~ws;
    if (with_ack) begin
      tick(3);
      check("head_before_ack", sample, exp_q[0]);
      ack = 1'b1;
      void'(exp_q.pop_front());
      tick(1);
      ack = 1'b0;
      commit_pend();
      tick(6);
    end else begin
      commit_pend();
      tick(8);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, level, exp_q.size());
    check({tag, "_rdy"}, rdy, exp_q.size() != 0);
    check({tag, "_ovr"}, ovr, exp_ovr);
    check({tag, "_cnt"}, ovr_cnt, cnt_out());
  endtask

  task automatic pop_check();
    check("pop_rdy", rdy, 1);
    check("pop_data", sample, exp_q[0]);
    void'(exp_q.pop_front());
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) pop_check();
    check({tag, "_empty_rdy"}, rdy, 0);
    check({tag, "_empty_level"}, level, 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 16, 32'h1111,  1'b0, 16'h0000};
    tbl[1] = '{1'b1, 12, 32'hABC,   1'b1, 16'hABC0};
    tbl[2] = '{1'b0, 8,  32'h55,    1'b0, 16'h0000};
    tbl[3] = '{1'b1, 20, 32'h12345, 1'b1, 16'h1234};
    tbl[4] = '{1'b0, 16, 32'hFFFF,  1'b0, 16'h0000};
    tbl[5] = '{1'b1, 0,  32'h0,     1'b0, 16'h0000};
    tbl[6] = '{1'b0, 4,  32'hF,     1'b0, 16'h0000};
    tbl[7] = '{1'b1, 16, 32'h8001,  1'b1, 16'h8001};

    rst = 1'b1; en = 1'b0; ch_sel = 1'b0; clr = 1'b0;
    sck = 1'b0; ws = 1'b0; sd = 1'b0; ack = 1'b0;
    tick(2);
    check("rst_sample", sample, 0);
    check_state("rst");
    rst = 1'b0;
    en = 1'b1;
    tick(2);

    // left word and commit latency
    start_slot(1'b1, 32'h0, 0, 1'b0, 16'h0);
    start_slot(1'b0, 32'hA5C3, 16, 1'b1, 16'hA5C3);
    ws = 1'b1;
    commit_pend();
    tick(3);
    check("lat_rdy_early", rdy, 0);
    tick(1);
    check("lat_rdy", rdy, 1);
    check("lat_sample", sample, 16'hA5C3);
    check("lat_level", level, 1);
    tick(4);
    drain("lat");

    // table of slots on the right channel
    ch_sel = 1'b1;
    for (int i = 0; i < 8; i++)
      start_slot(tbl[i].slot, tbl[i].data, tbl[i].nbits,
                 tbl[i].push, tbl[i].word);
    close_slot(0);
    check_state("tbl");
    for (int i = 0; i < 8; i++)
      if (tbl[i].push) begin
        check("tbl_word", sample, tbl[i].word);
        pop_check();
      end
    check("tbl_empty", rdy, 0);

    // overflow: five words into a depth of four
    for (int i = 0; i < 5; i++) begin
      start_slot(1'b1, 32'h1000 + i, 16, 1'b1, 16'h1000 + 16'(i));
      start_slot(1'b0, 32'h3, 2, 1'b0, 16'h0);
    end
    check_state("ovr");
    check("ovr_flag_set", ovr, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_ovr = 0;
    exp_cnt = 0;
    check_state("clr");

    // full FIFO, ack coincident with a commit
    start_slot(1'b1, 32'h2222, 16, 1'b1, 16'h2222);
    close_slot(1);
    check_state("full_ack");
    check("full_ack_head", sample, 16'h1001);
    drain("full_ack");

    // enable dropped mid-word
    start_slot(1'b1, 32'h7777, 16, 1'b1, 16'h7777);
    start_slot(1'b0, 32'h0, 4, 1'b0, 16'h0);
    start_slot(1'b1, 32'hBE, 8, 1'b0, 16'h0);
    en = 1'b0;
    tick(4);
    check_state("en_off");
    check("en_off_head", sample, 16'h7777);
    en = 1'b1;
    send_bits(32'hEF, 8);
    start_slot(1'b0, 32'h0, 4, 1'b0, 16'h0);
    check_state("en_idle");
    start_slot(1'b1, 32'h4242, 16, 1'b1, 16'h4242);
    close_slot(0);
    check_state("en_back");
    drain("en");

    // asynchronous reset mid-shift with two words queued
    start_slot(1'b1, 32'hC001, 16, 1'b1, 16'hC001);
    start_slot(1'b0, 32'h0, 4, 1'b0, 16'h0);
    start_slot(1'b1, 32'hC002, 16, 1'b1, 16'hC002);
    start_slot(1'b0, 32'h0, 0, 1'b0, 16'h0);
    start_slot(1'b1, 32'h1F, 5, 1'b1, 16'hF800);
    check("pre_rst_level", level, 2);
    #1 rst = 1'b1;
    #1;
    check("arst_sample", sample, 0);
    check("arst_rdy", rdy, 0);
    check("arst_level", level, 0);
    check("arst_ovr", ovr, 0);
    check("arst_cnt", ovr_cnt, 0);
    exp_q.delete();
    pend_v = 0;
    exp_ovr = 0;
    exp_cnt = 0;
    tick(2);
    ws = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    send_bits(32'hF, 4);
    check_state("post_rst_idle");
    start_slot(1'b1, 32'h5A5A, 16, 1'b1, 16'h5A5A);
    close_slot(0);
    check_state("post_rst");
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
